// File: rtl/block_decompressor_pkg.sv
// Shared types for the 32-pixel block decompressor.
// Header layout, pixel type, FSM states and field extension.
package block_decompressor_pkg;

  localparam int NUM_PIX = 32;
  localparam int NUM_CH  = 4;
  localparam int CH_W    = 8;
  localparam int HDR_W   = 48;

  typedef logic [NUM_CH-1:0][CH_W-1:0] pixel_t;

  typedef struct packed {
    logic [3:0][3:0] widths;
    logic [3:0][7:0] base;
  } blk_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    OUTPUT
  } dec_state_e;

  // Keep the low w bits of v; sign-extend them when sgn is set.
  function automatic logic [7:0] ext_field(
    input logic [7:0] v,
    input logic [3:0] w,
    input logic       sgn
  );
    logic [7:0] m;
    logic [7:0] f;
    logic [3:0] wm1;
    m   = ~(8'hFF << w);
    f   = v & m;
    wm1 = w - 4'd1;
    if (sgn && (w != 4'd0) && f[wm1[2:0]])
      f = f | ~m;
    return f;
  endfunction

endpackage

// File: rtl/block_decompressor_if.sv
// Header, payload and block handshakes of the decompressor.
// slave = decompressor side, master = surrounding logic.
interface block_decompressor_if;
  import block_decompressor_pkg::*;

  logic                    hdr_valid;
  logic                    hdr_ready;
  logic                    hdr_compressable;
  logic [HDR_W-1:0]        hdr;
  logic                    data_valid;
  logic                    data_ready;
  logic [31:0]             data;
  pixel_t [NUM_PIX-1:0]    pixels;
  logic                    blk_valid;
  logic                    blk_ready;
  logic                    err;

  modport slave (
    input  hdr_valid, hdr_compressable, hdr,
    input  data_valid, data, blk_ready,
    output hdr_ready, data_ready, pixels,
    output blk_valid, err
  );

  modport master (
    output hdr_valid, hdr_compressable, hdr,
    output data_valid, data, blk_ready,
    input  hdr_ready, data_ready, pixels,
    input  blk_valid, err
  );

endinterface

// File: rtl/block_decompressor_residual_unpacker.sv
// 64-bit LSB-first bit buffer: push 32-bit beats, pop need bits.
// Exposes the four extended channel fields at the buffer bottom.
module residual_unpacker
  import block_decompressor_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push,
  input  logic [31:0]     push_data,
  input  logic            pop,
  input  logic [5:0]      need,
  input  logic [3:0][3:0] widths,
  input  logic            sgn,
  output logic [6:0]      cnt,
  output pixel_t          fields
);

  logic [63:0] bits_q, bits_d, rem_bits;
  logic [6:0]  cnt_q, cnt_d, rem_cnt;
  logic [5:0]  off;

  // Pop first, then append the new beat above what remains.
  always_comb begin
    rem_bits = pop ? (bits_q >> need) : bits_q;
    rem_cnt  = pop ? (cnt_q - {1'b0, need}) : cnt_q;
    bits_d   = rem_bits;
    cnt_d    = rem_cnt;
    if (push) begin
      bits_d = rem_bits | ({32'd0, push_data} << rem_cnt);
      cnt_d  = rem_cnt + 7'd32;
    end
    if (clr) begin
      bits_d = '0;
      cnt_d  = '0;
    end
  end

  // Channel 0 sits lowest; each field starts after the previous.
  always_comb begin
    off    = '0;
    fields = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fields[c] = ext_field(8'(bits_q >> off), widths[c], sgn);
      off       = off + {2'b00, widths[c]};
    end
  end

  // Buffer and fill-level registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/block_decompressor.sv
// Rebuilds a 32-pixel RGBA block from header + residual stream.
// FSM, pixel index, base adders and pixel array live here.
module block_decompressor
  import block_decompressor_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  block_decompressor_if.slave  bus
);

  dec_state_e           state_q, state_d;
  logic [4:0]           pix_idx_q, pix_idx_d;
  logic [5:0]           beats_left_q, beats_left_d;
  logic [5:0]           need_q, need_d;
  logic [3:0][7:0]      base_q, base_d;
  logic [3:0][3:0]      w_q, w_d;
  logic                 raw_q, raw_d;
  logic                 err_q, err_d;
  logic                 hdr_ready_q, hdr_ready_d;
  logic                 blk_valid_q, blk_valid_d;
  pixel_t [NUM_PIX-1:0] pixels_q, pixels_d;

  blk_hdr_t   h;
  logic [6:0] cnt;
  logic [6:0] avail;
  pixel_t     fields;
  logic       ext, push, hs, bhs, rdy;
  logic [3:0] wc;

  residual_unpacker u_unpack (
    .clk       (clk),
    .rst       (rst),
    .clr       (hs),
    .push      (push),
    .push_data (bus.data),
    .pop       (ext),
    .need      (need_q),
    .widths    (w_q),
    .sgn       (~raw_q),
    .cnt       (cnt),
    .fields    (fields)
  );

  // Handshakes; data_ready leaves room for one beat after a pop.
  always_comb begin
    h     = blk_hdr_t'(bus.hdr);
    ext   = (state_q == DECODE) && (cnt >= {1'b0, need_q});
    avail = cnt - (ext ? {1'b0, need_q} : 7'd0);
    rdy   = (state_q == DECODE) && (beats_left_q != 6'd0)
            && (avail <= 7'd32);
    push  = bus.data_valid && rdy;
    hs    = bus.hdr_valid && hdr_ready_q;
    bhs   = blk_valid_q && bus.blk_ready;
  end

  // Next-state, header latch and pixel write.
  always_comb begin
    state_d      = state_q;
    pix_idx_d    = pix_idx_q;
    beats_left_d = beats_left_q;
    need_d       = need_q;
    base_d       = base_q;
    w_d          = w_q;
    raw_d        = raw_q;
    err_d        = err_q;
    pixels_d     = pixels_q;
    wc           = '0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          raw_d  = ~bus.hdr_compressable;
          need_d = '0;
          for (int c = 0; c < NUM_CH; c++) begin
            wc = (h.widths[c] > 4'd8) ? 4'd8 : h.widths[c];
            if (h.widths[c] > 4'd8) err_d = 1'b1;
            if (!bus.hdr_compressable) wc = 4'd8;
            w_d[c]    = wc;
            base_d[c] = bus.hdr_compressable ? h.base[c] : 8'd0;
            need_d    = need_d + {2'b00, wc};
          end
          pix_idx_d    = '0;
          beats_left_d = need_d;
          state_d      = DECODE;
        end
      end
      DECODE: begin
        if (push) beats_left_d = beats_left_q - 6'd1;
        if (ext) begin
          for (int c = 0; c < NUM_CH; c++)
            pixels_d[pix_idx_q][c] = base_q[c] + fields[c];
          pix_idx_d = pix_idx_q + 5'd1;
          if (pix_idx_q == 5'(NUM_PIX - 1)) state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bhs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    blk_valid_d = (state_q == OUTPUT) && !bhs;
    hdr_ready_d = (state_d == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pix_idx_q    <= '0;
      beats_left_q <= '0;
      need_q       <= '0;
      base_q       <= '0;
      w_q          <= '0;
      raw_q        <= 1'b0;
      err_q        <= 1'b0;
      hdr_ready_q  <= 1'b1;
      blk_valid_q  <= 1'b0;
      pixels_q     <= '0;
    end else begin
      state_q      <= state_d;
      pix_idx_q    <= pix_idx_d;
      beats_left_q <= beats_left_d;
      need_q       <= need_d;
      base_q       <= base_d;
      w_q          <= w_d;
      raw_q        <= raw_d;
      err_q        <= err_d;
      hdr_ready_q  <= hdr_ready_d;
      blk_valid_q  <= blk_valid_d;
      pixels_q     <= pixels_d;
    end
  end

  assign bus.hdr_ready  = hdr_ready_q;
  assign bus.data_ready = rdy;
  assign bus.blk_valid  = blk_valid_q;
  assign bus.pixels     = pixels_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_block_decompressor.sv
// Scoreboard bench for block_decompressor.
// Expected pixels queued at stimulus time, popped at blk_valid.
module tb_block_decompressor;
  import block_decompressor_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_decompressor_if bus ();

  block_decompressor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] beats [32];
  pixel_t      exp_q [$];

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_block(
    input logic [47:0] h,
    input logic        comp,
    input int          nb,
    input bit          gaps,
    input int          hold,
    input int          exp_lat
  );
    int          cyc;
    int          sent;
    int          edges;
    bit          stable;
    logic [1023:0] snap;
    pixel_t      e;
    @(negedge clk);
    bus.hdr              = h;
    bus.hdr_compressable = comp;
    bus.hdr_valid        = 1'b1;
    #1;
    cyc = 0;
    while (!bus.hdr_ready && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("hdr_ready_idle", 64'(bus.hdr_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.hdr_valid = 1'b0;
    sent  = 0;
    edges = 0;
    while (!bus.blk_valid && edges < 200) begin
      @(negedge clk);
      bus.data_valid = !gaps || ($urandom_range(0, 2) != 0);
      bus.data = (sent < 32) ? beats[sent] : 32'hFFFF_FFFF;
      #1;
      if (bus.data_valid && bus.data_ready) sent++;
      @(posedge clk);
      edges++;
      #1;
    end
    bus.data_valid = 1'b0;
    check("blk_valid", 64'(bus.blk_valid), 64'd1);
    check("beats_taken", 64'(sent), 64'(nb));
    if (exp_lat >= 0)
      check("latency", 64'(edges), 64'(exp_lat));
    else if (!gaps)
      check("latency_le34", 64'(edges <= 34), 64'd1);
    if (hold > 0) begin
      snap   = bus.pixels;
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (bus.pixels !== snap || !bus.blk_valid
            || bus.hdr_ready || bus.data_ready)
          stable = 1'b0;
      end
      check("hold_stable", 64'(stable), 64'd1);
    end
    for (int i = 0; i < NUM_PIX; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check($sformatf("pix%0d", i), 64'(bus.pixels[i]), 64'(e));
    end
    @(negedge clk);
    bus.blk_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.blk_ready = 1'b0;
    check("blk_valid_drop", 64'(bus.blk_valid), 64'd0);
    check("hdr_ready_back", 64'(bus.hdr_ready), 64'd1);
  endtask

  logic [47:0] h;
  pixel_t      p;
  logic [7:0]  sb;

  initial begin
    rst                  = 1'b0;
    bus.hdr_valid        = 1'b0;
    bus.hdr_compressable = 1'b0;
    bus.hdr              = '0;
    bus.data_valid       = 1'b0;
    bus.data             = '0;
    bus.blk_ready        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hdr_ready", 64'(bus.hdr_ready), 64'd1);
    check("rst_data_ready", 64'(bus.data_ready), 64'd0);
    check("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_pixels", 64'(|bus.pixels), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // zero widths: base only, no payload
    h = {16'h0000, 32'h4030_2010};
    for (int i = 0; i < 32; i++) exp_q.push_back(32'h4030_2010);
    run_block(h, 1'b1, 0, 1'b0, 0, 33);

    // full widths, base 0x80
    h = {16'h8888, 32'h8080_8080};
    for (int i = 0; i < 32; i++) begin
      beats[i] = {8'(i), 8'hFF, 8'h7F, 8'h80};
      exp_q.push_back({8'(8'h80 + i), 8'h7F, 8'hFF, 8'h00});
    end
    run_block(h, 1'b1, 32, 1'b0, 0, -1);

    // mixed widths 3,0,5,1, all-ones fields
    h = {4'd1, 4'd5, 4'd0, 4'd3, 32'h5050_5050};
    for (int i = 0; i < 32; i++) begin
      beats[i] = 32'hFFFF_FFFF;
      exp_q.push_back({8'h4F, 8'h4F, 8'h50, 8'h4F});
    end
    run_block(h, 1'b1, 9, 1'b0, 0, -1);

    // raw mode: pixels are the beats verbatim
    h[31:0] = $urandom;
    for (int c = 0; c < 4; c++)
      h[32 + 4*c +: 4] = 4'($urandom_range(0, 8));
    for (int i = 0; i < 32; i++) begin
      beats[i] = 32'hA0B0_C0D0 + 32'(i);
      exp_q.push_back(beats[i]);
    end
    run_block(h, 1'b0, 32, 1'b0, 0, -1);

    // backpressure: data gaps and blk_ready low 20 cycles
    h = {16'h8888, 32'h8080_8080};
    for (int i = 0; i < 32; i++) begin
      beats[i] = {8'(i), 8'hFF, 8'h7F, 8'h80};
      exp_q.push_back({8'(8'h80 + i), 8'h7F, 8'hFF, 8'h00});
    end
    run_block(h, 1'b1, 32, 1'b1, 20, -1);

    // reset in the middle of decoding pixel 12
    @(negedge clk);
    bus.hdr              = {16'h8888, 32'h8080_8080};
    bus.hdr_compressable = 1'b1;
    bus.hdr_valid        = 1'b1;
    @(posedge clk);
    #1;
    bus.hdr_valid  = 1'b0;
    bus.data_valid = 1'b1;
    repeat (13) @(posedge clk);
    @(negedge clk);
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_hdr_ready", 64'(bus.hdr_ready), 64'd1);
    check("mid_rst_blk_valid", 64'(bus.blk_valid), 64'd0);
    check("mid_rst_pixels", 64'(|bus.pixels), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    h = {4'd1, 4'd5, 4'd0, 4'd3, 32'h5050_5050};
    for (int i = 0; i < 32; i++) begin
      beats[i] = 32'hFFFF_FFFF;
      exp_q.push_back({8'h4F, 8'h4F, 8'h50, 8'h4F});
    end
    run_block(h, 1'b1, 9, 1'b0, 0, -1);
    check("err_clear", 64'(bus.err), 64'd0);

    // w0 = 12 clamps to 8 and sets err
    h = {4'd0, 4'd0, 4'd0, 4'd12, 32'h4433_2211};
    for (int i = 0; i < 32; i++) beats[i] = $urandom;
    for (int i = 0; i < 32; i++) begin
      sb = 8'(beats[i/4] >> (8 * (i % 4)));
      p  = {8'h44, 8'h33, 8'h22, 8'(8'h11 + sb)};
      exp_q.push_back(p);
    end
    run_block(h, 1'b1, 8, 1'b0, 0, -1);
    check("err_set", 64'(bus.err), 64'd1);

    // err stays set across a following clean block
    h = {16'h0000, 32'h0102_0304};
    for (int i = 0; i < 32; i++) exp_q.push_back(32'h0102_0304);
    run_block(h, 1'b1, 0, 1'b0, 0, 33);
    check("err_sticky", 64'(bus.err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
